lbus_bridge: RTL and testbench
==============================

Name: lbus_bridge

Overview:
- Byte-stream bridge directly upstream of the AES host interface block.
- Accepts command/address/data bytes from the host link (USB/controller FPGA side) on a valid/ready stream and buffers them in a TX FIFO. Paces them onto the HWE/HDIN strobe bus.
- Watches RRDYn and issues HRE pulses to pull read-back bytes into an RX FIFO, which drains to the host on a second valid/ready stream.
- Tracks the frame protocol, so the host may stream a whole command sequence without handshaking per byte.

Parameters:
TX_AW, 4, log2 depth of TX FIFO (16 bytes)
RX_AW, 4, log2 depth of RX FIFO (16 bytes)

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
S_DATA  in  8  host byte in
S_VALID  in  1  S_DATA valid
S_READY  out  1  TX FIFO not full
M_DATA  out  8  read-back byte to host
M_VALID  out  1  RX FIFO not empty
M_READY  in  1  host accepts M_DATA
DEVRDY  in  1  downstream ready; bridge idle while low
RRDYn  in  1  read byte available (active low)
WRDYn  in  1  downstream write busy (active high)
HRE  out  1  read strobe, registered
HWE  out  1  write strobe, registered
HDIN  out  8  write byte, registered, valid with HWE
HDOUT  in  8  read byte from downstream

Behaviour:
- Reset state: S_READY=0, M_VALID=0, M_DATA=00, HRE=0, HWE=0, HDIN=00. Both FIFOs empty, FSM=B_CMD, holdoff=0. S_READY goes 1 on the first cycle after reset release.
- TX FIFO:
  - Push when S_VALID&S_READY.
  - S_READY = !tx_full, where full = count==2^TX_AW.
  - Push and pop in the same cycle are allowed at any fill level, including full with a simultaneous pop. The count is unchanged in that case.
- Issue condition (evaluated each cycle): tx not empty & DEVRDY & !WRDYn & FSM != B_RWAIT.
  - When true, the next edge pops one byte, sets HWE=1 and HDIN=byte. Otherwise HWE=0 and HDIN holds.
  - Maximum rate is one byte per cycle, back-to-back.
- Frame FSM (advances only on the edge that issues a byte):
  - B_CMD: byte 00 -> B_RA (cnt=2); byte 01 -> B_WA (cnt=4); any other byte is forwarded and the FSM stays in B_CMD.
  - B_RA: cnt decrements per issued byte. When cnt reaches 0, go to B_RWAIT with rcnt=2.
  - B_WA: cnt decrements per issued byte. When cnt reaches 0, go to B_CMD.
  - B_RWAIT: no HWE is issued. Leave for B_CMD on the edge ending the second HRE cycle.
- Read pull (only in B_RWAIT):
  - Condition: RRDYn==0 & holdoff==0 & DEVRDY & rx not full (counting the in-flight byte).
  - When true, the next cycle has HRE=1 for exactly one cycle.
  - HDOUT is written into the RX FIFO on the edge ending that HRE cycle. rcnt decrements.
  - The same edge loads holdoff=3. Holdoff decrements to 0, so consecutive HRE pulses are separated by at least 3 low cycles. This covers the two-cycle stale RRDYn/HDOUT window downstream.
  - First captured byte = data[15:8], second = data[7:0].
- RX FIFO:
  - M_VALID = !rx_empty; M_DATA = head byte, first-word-fall-through.
  - Pop on M_VALID&M_READY. Simultaneous push and pop are allowed.
  - When full, HRE stalls and the downstream device waits. No byte is ever dropped.
- DEVRDY low: no HWE or HRE is issued. FIFOs still accept and drain.
- Reset mid-frame: everything returns to reset state and buffered bytes are lost. Downstream shares RSTn and also returns to its command state.

Test Plan:
1. After reset, hold DEVRDY=0 for 31 cycles while pushing 01 01 00 12 34 -> HWE stays 0 throughout. When DEVRDY=1: HWE high 5 consecutive cycles, HDIN=01,01,00,12,34, FSM ends in B_CMD, downstream key_reg[127:112]=1234.
2. Push 00 FF FC with M_READY=1 -> 3 HWE cycles, then 2 HRE pulses at least 3 cycles apart. M_DATA=45 then 22; no HWE until the second HRE completes.
3. Push 00 FF FC immediately followed by 01 00 02 00 01 -> the write bytes are held until the 22 is captured, then issue back-to-back. Downstream DATA_EN pulses once.
4. RX_AW=1, M_READY=0, issue two reads of FFFC -> after two bytes are captured, no further HRE. Raising M_READY yields 45,22,45,22 in order.
5. Fill the TX FIFO to 16 with DEVRDY=0 -> S_READY=0. Pop plus push in the same cycle keeps the count at 16.
6. Deassert RSTn during B_RWAIT between the two HRE pulses -> all outputs at reset values within the reset cycle. M_VALID=0 after release, and a new 00 FF FC read returns 45,22.

Source files
------------

// File: rtl/lbus_bridge.sv
// Host byte-stream to HWE/HDIN/HRE strobe-bus bridge with TX and RX FIFOs.
// A frame tracker blocks writes while a read reply is pulled from the device.
module lbus_bridge #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [7:0] S_DATA,
  input  logic       S_VALID,
  output logic       S_READY,
  output logic [7:0] M_DATA,
  output logic       M_VALID,
  input  logic       M_READY,
  input  logic       DEVRDY,
  input  logic       RRDYn,
  input  logic       WRDYn,
  output logic       HRE,
  output logic       HWE,
  output logic [7:0] HDIN,
  input  logic [7:0] HDOUT,
  output logic [1:0] dbg_state
);

  // Both streams: a byte moves on a rising edge where valid and ready are both high;
  // valid never waits on ready, and data is held stable while valid is high.
  localparam int TX_D = 1 << TX_AW;
  localparam int RX_D = 1 << RX_AW;
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_D);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_D);

  typedef enum logic [1:0] {B_CMD, B_RA, B_WA, B_RWAIT} bstate_t;

  bstate_t          state, state_n;
  logic [2:0]       cnt, cnt_n;
  logic [1:0]       rcnt, rcnt_n;
  logic [1:0]       holdoff, holdoff_n;
  logic             hre_q, hre_n;
  logic             hwe_q;
  logic [7:0]       hdin_q;
  logic             ready_en;

  logic [7:0]       tx_mem [TX_D];
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [TX_AW:0]   tx_cnt;
  logic             tx_push, tx_pop, tx_full;
  logic [7:0]       tx_byte;

  logic [7:0]       rx_mem [RX_D];
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [RX_AW:0]   rx_cnt;
  logic             rx_push, rx_pop, rx_empty, pull;

  assign tx_full = (tx_cnt == TX_FULL);
  assign tx_byte = tx_mem[tx_rp];
  assign tx_pop  = (tx_cnt != '0) && DEVRDY && !WRDYn && (state != B_RWAIT);
  // A full FIFO still accepts a byte on a cycle that also issues one.
  assign S_READY = ready_en && (!tx_full || tx_pop);
  assign tx_push = S_VALID && S_READY;

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp] <= S_DATA;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_cnt   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // The in-flight HRE byte is counted so the RX FIFO can never overflow.
  assign pull = (state == B_RWAIT) && !RRDYn && (holdoff == 2'd0) && DEVRDY &&
                !hre_q && (rcnt != 2'd0) &&
                ((rx_cnt + (RX_AW+1)'(hre_q)) < RX_FULL);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rcnt_n    = rcnt;
    holdoff_n = (holdoff != 2'd0) ? holdoff - 2'd1 : holdoff;
    hre_n     = pull;
    if (tx_pop) begin
      case (state)
        B_CMD: begin
          if (tx_byte == 8'h00) begin
            state_n = B_RA;
            cnt_n   = 3'd2;
          end else if (tx_byte == 8'h01) begin
            state_n = B_WA;
            cnt_n   = 3'd4;
          end
        end
        B_RA: begin
          cnt_n = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_n = B_RWAIT;
            rcnt_n  = 2'd2;
          end
        end
        B_WA: begin
          cnt_n = cnt - 3'd1;
          if (cnt == 3'd1) state_n = B_CMD;
        end
        default: state_n = state;
      endcase
    end
    // Holdoff spans the device's two-cycle stale RRDYn/HDOUT window.
    if (hre_q) begin
      rcnt_n    = rcnt - 2'd1;
      holdoff_n = 2'd3;
      if (rcnt == 2'd1) state_n = B_CMD;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= B_CMD;
      cnt     <= '0;
      rcnt    <= '0;
      holdoff <= '0;
      hre_q   <= 1'b0;
      hwe_q   <= 1'b0;
      hdin_q  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rcnt    <= rcnt_n;
      holdoff <= holdoff_n;
      hre_q   <= hre_n;
      hwe_q   <= tx_pop;
      if (tx_pop) hdin_q <= tx_byte;
    end
  end

  assign rx_push  = hre_q;
  assign rx_empty = (rx_cnt == '0);
  assign rx_pop   = !rx_empty && M_READY;

  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem[rx_wp] <= HDOUT;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  assign M_VALID   = !rx_empty;
  assign M_DATA    = rx_empty ? 8'h00 : rx_mem[rx_rp];
  assign HRE       = hre_q;
  assign HWE       = hwe_q;
  assign HDIN      = hdin_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_lbus_bridge.sv
// Directed bench for lbus_bridge with a behavioural downstream device that
// answers reads of FFFC with 4522 and holds RRDYn/HDOUT stale for two cycles.
module tb_lbus_bridge;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [7:0] S_DATA = 8'h00;
  logic       S_VALID = 1'b0;
  logic       S_READY;
  logic [7:0] M_DATA;
  logic       M_VALID;
  logic       M_READY = 1'b0;
  logic       DEVRDY = 1'b0;
  logic       RRDYn;
  logic       WRDYn = 1'b0;
  logic       HRE, HWE;
  logic [7:0] HDIN;
  logic [7:0] HDOUT;
  logic [1:0] dbg_state;

  always #5 CLK = ~CLK;

  lbus_bridge #(.TX_AW(4), .RX_AW(1)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .DEVRDY(DEVRDY), .RRDYn(RRDYn), .WRDYn(WRDYn),
    .HRE(HRE), .HWE(HWE), .HDIN(HDIN), .HDOUT(HDOUT),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- downstream device model ----------------
  logic [127:0] key_reg = '0;
  int           data_en_cnt = 0;
  int           dm_need;
  logic         dm_wr;
  logic [31:0]  dm_sh;
  logic [15:0]  rd_word;
  int           rd_left;
  int           stale;
  logic [31:0]  wr_full;
  logic [15:0]  rd_addr;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      dm_need <= 0;
      dm_wr   <= 1'b0;
      dm_sh   <= '0;
      RRDYn   <= 1'b1;
      HDOUT   <= 8'h00;
      rd_word <= '0;
      rd_left <= 0;
      stale   <= 0;
    end else begin
      if (HWE) begin
        if (dm_need == 0) begin
          dm_sh <= '0;
          if (HDIN == 8'h00) begin dm_wr <= 1'b0; dm_need <= 2; end
          else if (HDIN == 8'h01) begin dm_wr <= 1'b1; dm_need <= 4; end
        end else begin
          dm_need <= dm_need - 1;
          dm_sh   <= {dm_sh[23:0], HDIN};
          if (dm_need == 1) begin
            if (dm_wr) begin
              wr_full = {dm_sh[23:0], HDIN};
              if (wr_full[31:16] == 16'h0100) key_reg[127:112] <= wr_full[15:0];
              if (wr_full[31:16] == 16'h0002 && wr_full[0]) data_en_cnt <= data_en_cnt + 1;
            end else begin
              rd_addr = {dm_sh[7:0], HDIN};
              rd_word <= (rd_addr == 16'hFFFC) ? 16'h4522 : 16'h0000;
              HDOUT   <= (rd_addr == 16'hFFFC) ? 8'h45 : 8'h00;
              rd_left <= 2;
              RRDYn   <= 1'b0;
            end
          end
        end
      end
      if (HRE) begin
        rd_left <= rd_left - 1;
        stale   <= 2;
      end else if (stale == 1) begin
        stale <= 0;
        if (rd_left > 0) HDOUT <= rd_word[7:0];
        else RRDYn <= 1'b1;
      end else if (stale != 0) begin
        stale <= stale - 1;
      end
    end
  end

  // ---------------- monitor and RX scoreboard ----------------
  int         cyc = 0;
  int         last_hre = -1;
  int         pops = 0;
  logic [7:0] hwe_q[$];
  int         hwe_c[$];
  int         hre_c[$];
  logic [7:0] exp_q[$];

  always @(negedge CLK) begin
    cyc++;
    if (!RSTn) begin
      last_hre = -1;
    end else begin
      if (HWE) begin
        hwe_q.push_back(HDIN);
        hwe_c.push_back(cyc);
      end
      if (HRE) begin
        if (last_hre >= 0) check("hre_gap_ge4", int'(cyc - last_hre >= 4), 1);
        last_hre = cyc;
        hre_c.push_back(cyc);
      end
      if (M_VALID && M_READY) begin
        pops++;
        check("rx_expected_present", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("rx_data", int'(M_DATA), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] seq_q[$];
  logic [7:0] ref_q[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    S_DATA  = b;
    S_VALID = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge CLK);
      acc = S_READY;
      @(posedge CLK);
      #1;
    end
    check("push_accepted", int'(acc), 1);
  endtask

  task automatic push_seq();
    while (seq_q.size() > 0) push_byte(seq_q.pop_front());
    S_VALID = 1'b0;
  endtask

  task automatic clear_logs();
    hwe_q.delete();
    hwe_c.delete();
    hre_c.delete();
    pops = 0;
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 600 && pops < n; i++) tick(1);
    check("pop_count", pops, n);
  endtask

  task automatic wait_hre(input int n);
    for (int i = 0; i < 600 && hre_c.size() < n; i++) tick(1);
    check("hre_count_wait", hre_c.size(), n);
  endtask

  task automatic check_hwe_log(input string tag);
    check({tag, "_hwe_len"}, hwe_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size(); i++)
      check({tag, "_hdin"}, (i < hwe_q.size()) ? int'(hwe_q[i]) : 32'h1FF, int'(ref_q[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, int'(S_READY), 0);
    check({tag, "_m_valid"}, int'(M_VALID), 0);
    check({tag, "_m_data"},  int'(M_DATA), 0);
    check({tag, "_hre"},     int'(HRE), 0);
    check({tag, "_hwe"},     int'(HWE), 0);
    check({tag, "_hdin"},    int'(HDIN), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int den0;

  initial begin
    tick(3);
    check_reset_outputs("rst");
    check("rst_state", int'(dbg_state), 0);
    RSTn = 1'b1;
    tick(1);
    check("s_ready_after_release", int'(S_READY), 1);

    // 1: write 1234 to 0100 while device not ready, then release
    clear_logs();
    seq_q = {8'h01, 8'h01, 8'h00, 8'h12, 8'h34};
    ref_q = seq_q;
    push_seq();
    tick(26);
    check("t1_no_hwe_devrdy_low", hwe_q.size(), 0);
    DEVRDY = 1'b1;
    tick(12);
    check_hwe_log("t1");
    check("t1_back_to_back", hwe_c.size() == 5 ? hwe_c[4] - hwe_c[0] : -1, 4);
    check("t1_state_cmd", int'(dbg_state), 0);
    check("t1_key_reg", int'(key_reg[127:112]), 32'h1234);

    // 2: read FFFC
    clear_logs();
    M_READY = 1'b1;
    exp_q = {8'h45, 8'h22};
    seq_q = {8'h00, 8'hFF, 8'hFC};
    ref_q = seq_q;
    push_seq();
    wait_pops(2);
    tick(5);
    check_hwe_log("t2");
    check("t2_hre_count", hre_c.size(), 2);
    check("t2_gap", hre_c.size() == 2 ? int'(hre_c[1] - hre_c[0] >= 4) : 0, 1);
    check("t2_sb_drained", exp_q.size(), 0);

    // 3: read immediately followed by a DATA_EN write
    clear_logs();
    den0 = data_en_cnt;
    exp_q = {8'h45, 8'h22};
    seq_q = {8'h00, 8'hFF, 8'hFC, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01};
    ref_q = seq_q;
    push_seq();
    wait_pops(2);
    tick(10);
    check_hwe_log("t3");
    check("t3_hre_count", hre_c.size(), 2);
    check("t3_write_after_read",
          (hwe_c.size() == 8 && hre_c.size() == 2) ? int'(hwe_c[3] > hre_c[1]) : 0, 1);
    check("t3_write_back_to_back", hwe_c.size() == 8 ? hwe_c[7] - hwe_c[3] : -1, 4);
    check("t3_data_en_once", data_en_cnt - den0, 1);

    // 4: RX FIFO of two bytes fills and stalls the second read
    clear_logs();
    M_READY = 1'b0;
    seq_q = {8'h00, 8'hFF, 8'hFC, 8'h00, 8'hFF, 8'hFC};
    push_seq();
    tick(60);
    check("t4_hre_stalled", hre_c.size(), 2);
    check("t4_m_valid", int'(M_VALID), 1);
    check("t4_m_data_head", int'(M_DATA), 32'h45);
    check("t4_state_rwait", int'(dbg_state), 3);
    exp_q = {8'h45, 8'h22, 8'h45, 8'h22};
    M_READY = 1'b1;
    wait_pops(4);
    tick(5);
    check("t4_hre_total", hre_c.size(), 4);
    check("t4_hwe_total", hwe_q.size(), 6);
    check("t4_sb_drained", exp_q.size(), 0);

    // 5: fill the TX FIFO, then push and pop in one cycle
    clear_logs();
    DEVRDY = 1'b0;
    for (int i = 0; i < 16; i++) seq_q.push_back(8'h55);
    push_seq();
    tick(1);
    check("t5_full_not_ready", int'(S_READY), 0);
    S_DATA  = 8'h56;
    S_VALID = 1'b1;
    DEVRDY  = 1'b1;
    #1;
    check("t5_ready_with_pop", int'(S_READY), 1);
    tick(1);
    S_VALID = 1'b0;
    DEVRDY  = 1'b0;
    #1;
    check("t5_still_full", int'(S_READY), 0);
    tick(1);
    check("t5_one_issued", hwe_q.size(), 1);
    DEVRDY = 1'b1;
    tick(25);
    check("t5_all_issued", hwe_q.size(), 17);
    check("t5_last_byte", hwe_q.size() == 17 ? int'(hwe_q[16]) : 32'h1FF, 32'h56);
    check("t5_prev_byte", hwe_q.size() == 17 ? int'(hwe_q[15]) : 32'h1FF, 32'h55);
    check("t5_ready_again", int'(S_READY), 1);

    // 6: reset between the two HRE pulses, then a fresh read
    clear_logs();
    exp_q = {8'h45, 8'h22};
    seq_q = {8'h00, 8'hFF, 8'hFC};
    push_seq();
    wait_hre(1);
    tick(1);
    #2;
    RSTn = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    tick(2);
    RSTn = 1'b1;
    tick(1);
    check("t6_m_valid_after_release", int'(M_VALID), 0);
    clear_logs();
    exp_q = {8'h45, 8'h22};
    seq_q = {8'h00, 8'hFF, 8'hFC};
    ref_q = seq_q;
    push_seq();
    wait_pops(2);
    tick(5);
    check_hwe_log("t6");
    check("t6_hre_count", hre_c.size(), 2);
    check("t6_sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
